// File: rtl/div_unit.sv
// div_unit: 32-bit radix-2 restoring divider for DIV/DIVU in EX.
// Holds the pipeline front stalled while iterating; LO=quotient, HI=remainder.
module div_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        signed_div,
  input  logic [31:0] dividend,
  input  logic [31:0] divisor,
  input  logic        annul,
  output logic [31:0] quotient,
  output logic [31:0] remainder,
  output logic        ready,
  output logic        busy,
  output logic        stallreq_for_ex
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ZERO,
    S_ON,
    S_END
  } state_e;

  state_e      state_q, state_d;
  logic [5:0]  cnt_q, cnt_d;
  logic [64:0] wr_q, wr_d;
  logic [31:0] dsr_q, dsr_d;
  logic        q_neg_q, q_neg_d;
  logic        r_neg_q, r_neg_d;
  logic [31:0] quo_q, quo_d;
  logic [31:0] rem_q, rem_d;

  logic [31:0] dvd_mag;
  logic [31:0] dsr_mag;
  logic [65:0] shl;
  logic [33:0] diff;
  logic [64:0] step;
  logic [31:0] q_fin;
  logic [31:0] r_fin;

  // operand magnitudes taken at latch time in signed mode
  always_comb begin
    dvd_mag = dividend;
    dsr_mag = divisor;
    if (signed_div && dividend[31]) begin
      dvd_mag = -dividend;
    end
    if (signed_div && divisor[31]) begin
      dsr_mag = -divisor;
    end
  end

  // one restoring step: shift, trial subtract, keep or restore
  always_comb begin
    shl  = {wr_q, 1'b0};
    diff = shl[65:32] - {2'b00, dsr_q};
    if (diff[33]) begin
      step = shl[64:0];
    end else begin
      step = {diff[32:0], shl[31:1], 1'b1};
    end
  end

  // sign fix-up applied to the final step's result
  always_comb begin
    q_fin = step[31:0];
    r_fin = step[63:32];
    if (q_neg_q) begin
      q_fin = -step[31:0];
    end
    if (r_neg_q) begin
      r_fin = -step[63:32];
    end
  end

  // next-state and datapath control
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    wr_d    = wr_q;
    dsr_d   = dsr_q;
    q_neg_d = q_neg_q;
    r_neg_d = r_neg_q;
    quo_d   = quo_q;
    rem_d   = rem_q;
    if (annul) begin
      state_d = S_IDLE;
      cnt_d   = 6'd0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (start) begin
            dsr_d   = dsr_mag;
            q_neg_d = signed_div & (dividend[31] ^ divisor[31]);
            r_neg_d = signed_div & dividend[31];
            cnt_d   = 6'd0;
            if (divisor == 32'd0) begin
              state_d = S_ZERO;
              wr_d    = {33'd0, dividend};
            end else begin
              state_d = S_ON;
              wr_d    = {33'd0, dvd_mag};
            end
          end
        end
        S_ZERO: begin
          quo_d   = 32'hFFFF_FFFF;
          rem_d   = wr_q[31:0];
          state_d = S_END;
        end
        S_ON: begin
          wr_d  = step;
          cnt_d = cnt_q + 6'd1;
          if (cnt_q == 6'd31) begin
            state_d = S_END;
            quo_d   = q_fin;
            rem_d   = r_fin;
          end
        end
        S_END: begin
          state_d = S_IDLE;
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end
  end

  // state and datapath registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      cnt_q   <= 6'd0;
      wr_q    <= 65'd0;
      dsr_q   <= 32'd0;
      q_neg_q <= 1'b0;
      r_neg_q <= 1'b0;
      quo_q   <= 32'd0;
      rem_q   <= 32'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      wr_q    <= wr_d;
      dsr_q   <= dsr_d;
      q_neg_q <= q_neg_d;
      r_neg_q <= r_neg_d;
      quo_q   <= quo_d;
      rem_q   <= rem_d;
    end
  end

  // status decode; stall is forced low in reset and on a flush
  always_comb begin
    quotient        = quo_q;
    remainder       = rem_q;
    ready           = (state_q == S_END);
    busy            = (state_q != S_IDLE);
    stallreq_for_ex = rst & ~annul &
                      ((state_q == S_IDLE & start) |
                       (state_q == S_ON) |
                       (state_q == S_ZERO));
  end

endmodule

// File: tb/tb_div_unit.sv
// tb_div_unit: random and directed checks of div_unit
// against an arithmetic reference model.
module tb_div_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic        signed_div = 1'b0;
  logic        annul = 1'b0;
  logic [31:0] dividend = '0;
  logic [31:0] divisor = '0;
  logic [31:0] quotient;
  logic [31:0] remainder;
  logic        ready;
  logic        busy;
  logic        stallreq_for_ex;

  int checks = 0;
  int errors = 0;

  div_unit dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .signed_div(signed_div),
    .dividend(dividend),
    .divisor(divisor),
    .annul(annul),
    .quotient(quotient),
    .remainder(remainder),
    .ready(ready),
    .busy(busy),
    .stallreq_for_ex(stallreq_for_ex)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  // reference: plain 64-bit arithmetic, truncating toward zero
  task automatic model(input logic [31:0] a,
                       input logic [31:0] b,
                       input logic s,
                       output logic [31:0] q,
                       output logic [31:0] r);
    longint sa;
    longint sb;
    longint lq;
    longint lr;
    if (b == 32'd0) begin
      q = 32'hFFFF_FFFF;
      r = a;
    end else begin
      if (s) begin
        sa = {{32{a[31]}}, a};
        sb = {{32{b[31]}}, b};
      end else begin
        sa = {32'd0, a};
        sb = {32'd0, b};
      end
      lq = sa / sb;
      lr = sa % sb;
      q = lq[31:0];
      r = lr[31:0];
    end
  endtask

  // caller is positioned at a negedge in an IDLE cycle
  task automatic run(input logic [31:0] a,
                     input logic [31:0] b,
                     input logic s,
                     input string tag);
    logic [31:0] eq;
    logic [31:0] er;
    int lat;
    int k;
    bit ok;
    model(a, b, s, eq, er);
    lat = (b == 32'd0) ? 2 : 33;
    start = 1'b1;
    signed_div = s;
    dividend = a;
    divisor = b;
    #1;
    ok = (stallreq_for_ex === 1'b1) && (ready === 1'b0);
    k = 0;
    while (ready !== 1'b1 && k < 100) begin
      @(negedge clk);
      k++;
      if (ready !== 1'b1 && stallreq_for_ex !== 1'b1) ok = 0;
      if (ready === 1'b1 && stallreq_for_ex !== 1'b0) ok = 0;
    end
    chk({tag, "_lat"}, k, lat);
    chk({tag, "_stall"}, {31'd0, ok}, 32'd1);
    chk({tag, "_q"}, quotient, eq);
    chk({tag, "_r"}, remainder, er);
    start = 1'b0;
    @(negedge clk);
    chk({tag, "_idle"}, {30'd0, ready, busy}, 32'd0);
  endtask

  initial begin
    logic [31:0] a;
    logic [31:0] b;
    logic        s;
    bit          saw;

    start = 1'b1;
    #1;
    chk("rst_q", quotient, 32'd0);
    chk("rst_r", remainder, 32'd0);
    chk("rst_flags", {29'd0, ready, busy, stallreq_for_ex}, 32'd0);
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    run(32'd100, 32'd7, 1'b0, "divu_100_7");
    run(32'hFFFF_FFF9, 32'd2, 1'b1, "div_m7_2");
    run(32'd7, 32'hFFFF_FFFE, 1'b1, "div_7_m2");
    run(32'h1234, 32'd0, 1'b0, "divu_zero");
    run(32'h1234, 32'd0, 1'b1, "div_zero");
    run(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, "div_ovf");
    run(32'hFFFF_FFFF, 32'd1, 1'b0, "divu_max");
    run(32'hFFFF_FFF0, 32'd0, 1'b1, "div_zero_neg");

    // flush in the middle of an iteration
    start = 1'b1;
    signed_div = 1'b0;
    dividend = 32'hDEAD_BEEF;
    divisor = 32'd5;
    saw = 0;
    repeat (10) begin
      @(negedge clk);
      if (ready) saw = 1;
    end
    annul = 1'b1;
    #1;
    chk("annul_stall", {31'd0, stallreq_for_ex}, 32'd0);
    @(negedge clk);
    annul = 1'b0;
    chk("annul_idle", {30'd0, busy, ready}, 32'd0);
    chk("annul_no_rdy", {31'd0, saw}, 32'd0);
    run(32'd9, 32'd3, 1'b0, "post_annul");

    // start together with annul in IDLE latches nothing
    start = 1'b1;
    annul = 1'b1;
    dividend = 32'd50;
    divisor = 32'd5;
    #1;
    chk("sa_stall", {31'd0, stallreq_for_ex}, 32'd0);
    @(negedge clk);
    chk("sa_busy", {31'd0, busy}, 32'd0);
    start = 1'b0;
    annul = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 30; i++) begin
      a = $urandom;
      s = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 4))
        0: b = 32'd0;
        1: b = 32'($urandom_range(1, 15));
        2: b = 32'd0 - 32'($urandom_range(1, 15));
        3: b = a >> $urandom_range(0, 31);
        default: b = $urandom;
      endcase
      if (i % 7 == 3) a = 32'h8000_0000;
      run(a, b, s, $sformatf("rnd%0d", i));
    end

    // asynchronous reset between clock edges mid-iteration
    run(32'hFFFF_FF00, 32'd3, 1'b0, "pre_rst");
    start = 1'b1;
    dividend = 32'h7777_7777;
    divisor = 32'd3;
    repeat (5) @(negedge clk);
    #2;
    rst = 1'b0;
    #1;
    chk("arst_q", quotient, 32'd0);
    chk("arst_r", remainder, 32'd0);
    chk("arst_flags", {29'd0, ready, busy, stallreq_for_ex}, 32'd0);
    @(negedge clk);
    start = 1'b0;
    rst = 1'b1;
    saw = 0;
    repeat (40) begin
      @(negedge clk);
      if (ready) saw = 1;
    end
    chk("arst_no_rdy", {31'd0, saw}, 32'd0);
    run(32'd1000, 32'd10, 1'b0, "after_rst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
